data_sram_slave: RTL and testbench
==================================

DATA_SRAM_SLAVE -- requirements
Module: data_sram_slave

Interface
REQ-001 Parameter LATENCY, default 2, meaning cycles from request acceptance to data_ok; legal range 1..7.
REQ-002 Parameter AW, default 10, meaning word-address width of the backing RAM port.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 req  input  1  master request valid.
REQ-006 wr  input  1  1 = write, 0 = read.
REQ-007 size  input  2  0 = byte, 1 = half, 2 or 3 = word.
REQ-008 addr  input  32  byte address.
REQ-009 wdata  input  32  write data, already lane-replicated by the master.
REQ-010 addr_ok  output  1  request accepted this cycle when req && addr_ok.
REQ-011 data_ok  output  1  one response completes this cycle.
REQ-012 rdata  output  32  read data, valid with data_ok.
REQ-013 ram_en  output  1  backing-RAM access enable.
REQ-014 ram_wen  output  4  backing-RAM byte write enables.
REQ-015 ram_addr  output  AW  backing-RAM word address, equal to addr[AW+1:2].
REQ-016 ram_wdata  output  32  backing-RAM write data, equal to wdata.
REQ-017 ram_rdata  input  32  backing-RAM read data, valid one cycle after ram_en.

Function
REQ-018 The block shall hold at most 2 outstanding requests in an in-order response queue with entries {valid, wr, cnt[2:0], data[31:0], captured}.
REQ-019 addr_ok shall be 1 when the queue holds fewer than 2 entries, or when it holds 2 entries and data_ok is 1 in the same cycle.
REQ-020 On acceptance, the block shall drive ram_en=1 combinationally in the same cycle; ram_en shall be 0 in all other cycles.
REQ-021 ram_wen shall be 0000 for reads.
REQ-022 For writes, ram_wen shall be: byte -> 0001 shifted left by addr[1:0]; half -> addr[1] ? 1100 : 0011; word -> 1111.
REQ-023 The block shall not check alignment.
REQ-024 An accepted entry shall load cnt = LATENCY-1 and captured = 0.
REQ-025 Every valid entry with cnt != 0 shall decrement cnt by 1 each cycle.
REQ-026 One cycle after acceptance, a read entry shall capture ram_rdata into data and set captured = 1.
REQ-027 data_ok shall be 1 exactly when the head entry is valid and its cnt == 0.
REQ-028 rdata shall equal the head's data if captured = 1, otherwise ram_rdata (LATENCY=1 bypass).
REQ-029 rdata shall be 32'h0 for write responses and when data_ok = 0.
REQ-030 On data_ok, the head shall retire, the second entry shall become the head, and a request accepted in the same cycle shall enter the freed slot.
REQ-031 data_ok shall not be back-pressured; the master shall consume it in the cycle it is asserted.
REQ-032 Responses shall return in acceptance order.
REQ-033 Back-to-back accepted requests shall complete on consecutive cycles.

Reset
REQ-034 While resetn = 0, all queue entries shall be invalid, cnt and data shall be 0, and addr_ok = 1, data_ok = 0, rdata = 0, ram_en = 0, ram_wen = 0.
REQ-035 Assertion of resetn mid-transaction shall discard all outstanding entries; no data_ok shall follow for them.
REQ-036 The first acceptance after reset release shall be possible in the first clock edge with resetn = 1.

Verification
REQ-037 LATENCY=2; read addr=0x10, RAM word 4 = 0xA5A5_1234 -> ram_en=1 and ram_addr=4 at cycle T; data_ok=1 and rdata=0xA5A5_1234 at T+2 only.
REQ-038 Write size=0, addr=0x7, wdata=0x5A5A_5A5A -> ram_wen=1000 and ram_addr=1 at acceptance; data_ok with rdata=0 two cycles later.
REQ-039 req held high for 4 consecutive cycles of reads -> addr_ok=1 on every cycle; data_ok on 4 consecutive cycles starting 2 cycles later; data returned in order.
REQ-040 LATENCY=3 with req held high -> addr_ok drops to 0 in the third cycle (queue full) and returns to 1 in the cycle the first data_ok fires, accepting simultaneously.
REQ-041 LATENCY=1; read addr=0x0 -> data_ok in cycle T+1 with rdata driven directly from ram_rdata (bypass).
REQ-042 resetn pulsed low while 2 reads are outstanding -> no data_ok afterwards; addr_ok=1; queue empty.

Source files
------------

// File: rtl/data_sram_slave.sv
// SRAM-like slave bridging a req/addr_ok/data_ok master onto a one-cycle-latency RAM port.
// Fixed LATENCY-cycle responses, up to two in flight; addr_ok deasserts only when both slots are busy.
module data_sram_slave #(
  parameter int LATENCY = 2,
  parameter int AW      = 10
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          req,
  input  logic          wr,
  input  logic [1:0]    size,
  input  logic [31:0]   addr,
  input  logic [31:0]   wdata,
  output logic          addr_ok,
  output logic          data_ok,
  output logic [31:0]   rdata,
  output logic          ram_en,
  output logic [3:0]    ram_wen,
  output logic [AW-1:0] ram_addr,
  output logic [31:0]   ram_wdata,
  input  logic [31:0]   ram_rdata
);

  typedef struct packed {
    logic        valid;
    logic        wr;
    logic [2:0]  cnt;
    logic [31:0] data;
    logic        captured;
  } entry_t;

  localparam logic [2:0] CNT_INIT = 3'(LATENCY - 1);

  entry_t     q   [2];
  entry_t     upd [2];
  entry_t     nxt [2];
  entry_t     new_e;
  logic       cap_pend;
  logic       push;
  logic [3:0] wmask;
  logic       unused_addr;

  assign unused_addr = ^addr[31:AW+2];

  assign data_ok = q[0].valid && (q[0].cnt == 3'd0);
  assign addr_ok = !(q[0].valid && q[1].valid) || data_ok;
  // Gating with resetn keeps the RAM port quiet while the block is held in reset.
  assign push    = req && addr_ok && resetn;

  always_comb begin
    wmask = 4'b1111;
    case (size)
      2'd0:    wmask = 4'b0001 << addr[1:0];
      2'd1:    wmask = addr[1] ? 4'b1100 : 4'b0011;
      default: wmask = 4'b1111;
    endcase
  end

  assign ram_en    = push;
  assign ram_wen   = (push && wr) ? wmask : 4'b0000;
  assign ram_addr  = addr[AW+1:2];
  assign ram_wdata = wdata;

  // LATENCY=1 retires before the capture edge, so the head reads straight from the RAM.
  always_comb begin
    rdata = 32'h0;
    if (data_ok && !q[0].wr)
      rdata = q[0].captured ? q[0].data : ram_rdata;
  end

  always_comb begin
    upd = q;
    for (int i = 0; i < 2; i++) begin
      if (upd[i].valid && upd[i].cnt != 3'd0)
        upd[i].cnt = upd[i].cnt - 3'd1;
    end

    // The entry accepted last cycle is always the tail of the queue.
    if (cap_pend) begin
      if (q[1].valid) begin
        if (!upd[1].wr) begin
          upd[1].data     = ram_rdata;
          upd[1].captured = 1'b1;
        end
      end else if (!upd[0].wr) begin
        upd[0].data     = ram_rdata;
        upd[0].captured = 1'b1;
      end
    end

    if (data_ok) begin
      nxt[0] = upd[1];
      nxt[1] = '0;
    end else begin
      nxt[0] = upd[0];
      nxt[1] = upd[1];
    end

    new_e          = '0;
    new_e.valid    = 1'b1;
    new_e.wr       = wr;
    new_e.cnt      = CNT_INIT;
    new_e.captured = 1'b0;

    if (push) begin
      if (!nxt[0].valid) nxt[0] = new_e;
      else               nxt[1] = new_e;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 2; i++) q[i] <= '0;
      cap_pend <= 1'b0;
    end else begin
      for (int i = 0; i < 2; i++) q[i] <= nxt[i];
      cap_pend <= push;
    end
  end

endmodule

// File: tb/tb_data_sram_slave.sv
// Scoreboard bench: three instances at LATENCY 2, 3 and 1 behind a behavioural one-cycle RAM.
module tb_data_sram_slave;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  req, wr;
  logic [1:0]  size      [3];
  logic [31:0] addr      [3];
  logic [31:0] wdata     [3];
  logic [2:0]  addr_ok, data_ok, ram_en;
  logic [31:0] rdata     [3];
  logic [3:0]  ram_wen   [3];
  logic [9:0]  ram_addr  [3];
  logic [31:0] ram_wdata [3];
  logic [31:0] ram_rdata [3];

  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  logic [63:0] q0[$], q1[$], q2[$];
  logic [63:0] e;
  logic        have;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    data_sram_slave #(.LATENCY(g == 0 ? 2 : (g == 1 ? 3 : 1)), .AW(10)) u_dut (
      .clk(clk), .resetn(resetn), .req(req[g]), .wr(wr[g]), .size(size[g]),
      .addr(addr[g]), .wdata(wdata[g]), .addr_ok(addr_ok[g]), .data_ok(data_ok[g]),
      .rdata(rdata[g]), .ram_en(ram_en[g]), .ram_wen(ram_wen[g]), .ram_addr(ram_addr[g]),
      .ram_wdata(ram_wdata[g]), .ram_rdata(ram_rdata[g])
    );
  end

  // Read-only RAM image: word 4 holds A5A5_1234, every other word is {C0DE, instance, index}.
  always @(posedge clk)
    for (int k = 0; k < 3; k++)
      if (ram_en[k])
        ram_rdata[k] <= (ram_addr[k] == 10'd4) ? 32'hA5A5_1234
                                               : {16'hC0DE, 8'(k), ram_addr[k][7:0]};

  task automatic check(string name, int k, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d: got %0h expected %0h (cycle %0d)", name, k, act, exp, cyc);
    end
  endtask

  function automatic int lat_of(int k);
    return (k == 0) ? 2 : ((k == 1) ? 3 : 1);
  endfunction

  task automatic push_exp(int k, logic [31:0] due, logic [31:0] d);
    case (k)
      0:       q0.push_back({due, d});
      1:       q1.push_back({due, d});
      default: q2.push_back({due, d});
    endcase
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (data_ok[k]) begin
        have = 1'b0;
        e    = '0;
        case (k)
          0:       if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          1:       if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
          default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) check("unexpected_data_ok", k, 64'(data_ok[k]), 64'd0);
        else begin
          check("resp_cycle", k, 64'(cyc), 64'(e[63:32]));
          check("resp_rdata", k, 64'(rdata[k]), 64'(e[31:0]));
        end
      end else begin
        check("rdata_idle_zero", k, 64'(rdata[k]), 64'd0);
      end
    end
  end

  // Called at posedge+1; returns at the next posedge+1 with req dropped.
  task automatic issue(int k, logic w, logic [1:0] s, logic [31:0] a, logic [31:0] d,
                       logic exp_ok, logic [3:0] exp_wen, logic [31:0] exp_rd);
    req[k] = 1'b1; wr[k] = w; size[k] = s; addr[k] = a; wdata[k] = d;
    @(negedge clk);
    check("addr_ok", k, 64'(addr_ok[k]), 64'(exp_ok));
    check("ram_en", k, 64'(ram_en[k]), 64'(exp_ok));
    check("ram_wen", k, 64'(ram_wen[k]), 64'(exp_wen));
    if (exp_ok) begin
      check("ram_addr", k, 64'(ram_addr[k]), 64'(a[11:2]));
      if (w) check("ram_wdata", k, 64'(ram_wdata[k]), 64'(d));
      push_exp(k, 32'(cyc + lat_of(k)), exp_rd);
    end
    @(posedge clk); #1;
    req[k] = 1'b0;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  typedef struct { logic [1:0] s; logic [31:0] a; logic [3:0] wen; } wcase_t;
  wcase_t wtab [5] = '{
    '{2'd0, 32'h31, 4'b0010}, '{2'd1, 32'h32, 4'b1100}, '{2'd1, 32'h30, 4'b0011},
    '{2'd2, 32'h30, 4'b1111}, '{2'd3, 32'h33, 4'b1111}
  };
  logic [31:0] rd_exp0 [4] = '{32'hC0DE_0008, 32'hC0DE_0009, 32'hC0DE_000A, 32'hC0DE_000B};
  logic        ok_l3   [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

  initial begin
    int word;
    resetn = 1'b0;
    req = '0; wr = '0;
    for (int k = 0; k < 3; k++) begin
      size[k] = '0; addr[k] = '0; wdata[k] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    req[0] = 1'b1; addr[0] = 32'h10;
    @(negedge clk);
    check("rst_addr_ok", 0, 64'(addr_ok[0]), 64'd1);
    check("rst_data_ok", 0, 64'(data_ok[0]), 64'd0);
    check("rst_ram_en", 0, 64'(ram_en[0]), 64'd0);
    check("rst_ram_wen", 0, 64'(ram_wen[0]), 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // First edge after release accepts; word 4 returns two cycles later.
    issue(0, 1'b0, 2'd2, 32'h10, 32'h0, 1'b1, 4'b0000, 32'hA5A5_1234);
    idle(3);
    issue(0, 1'b1, 2'd0, 32'h7, 32'h5A5A_5A5A, 1'b1, 4'b1000, 32'h0);
    idle(3);
    for (int i = 0; i < 5; i++)
      issue(0, 1'b1, wtab[i].s, wtab[i].a, 32'h1234_5678, 1'b1, wtab[i].wen, 32'h0);
    idle(3);
    for (int i = 0; i < 4; i++)
      issue(0, 1'b0, 2'd2, 32'h20 + 32'(4 * i), 32'h0, 1'b1, 4'b0000, rd_exp0[i]);
    idle(4);

    // LATENCY=3 with req held: queue fills on the third cycle, reopens with each data_ok.
    word = 0;
    for (int i = 0; i < 6; i++) begin
      issue(1, 1'b0, 2'd2, 32'(4 * word), 32'h0, ok_l3[i], 4'b0000,
            {16'hC0DE, 8'd1, 8'(word)});
      if (ok_l3[i]) word++;
    end
    idle(5);

    // LATENCY=1 bypass, single then back-to-back.
    issue(2, 1'b0, 2'd2, 32'h0, 32'h0, 1'b1, 4'b0000, 32'hC0DE_0200);
    idle(2);
    issue(2, 1'b0, 2'd2, 32'h4, 32'h0, 1'b1, 4'b0000, 32'hC0DE_0201);
    issue(2, 1'b1, 2'd2, 32'h8, 32'hFFFF_0000, 1'b1, 4'b1111, 32'h0);
    issue(2, 1'b0, 2'd2, 32'h8, 32'h0, 1'b1, 4'b0000, 32'hC0DE_0202);
    idle(3);

    // Reset with two reads in flight, just before the first would complete.
    issue(0, 1'b0, 2'd2, 32'h10, 32'h0, 1'b1, 4'b0000, 32'hA5A5_1234);
    issue(0, 1'b0, 2'd2, 32'h20, 32'h0, 1'b1, 4'b0000, 32'hC0DE_0008);
    resetn = 1'b0;
    q0.delete(); q1.delete(); q2.delete();
    @(negedge clk);
    check("mid_rst_data_ok", 0, 64'(data_ok[0]), 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    idle(5);
    @(negedge clk);
    check("post_rst_addr_ok", 0, 64'(addr_ok[0]), 64'd1);
    @(posedge clk); #1;
    issue(0, 1'b0, 2'd2, 32'h24, 32'h0, 1'b1, 4'b0000, 32'hC0DE_0009);
    idle(4);

    check("drain", 0, 64'(q0.size()), 64'd0);
    check("drain", 1, 64'(q1.size()), 64'd0);
    check("drain", 2, 64'(q2.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
